stack_alu_sequencer: RTL and testbench

STACK_ALU_SEQUENCER -- requirements
Module: stack_alu_sequencer

---
 rtl/stack_alu_sequencer.sv | 107 ++++++++++
 tb/tb_stack_alu_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: sequences stack-machine instructions against an external program stack.
module stack_alu_sequencer #(
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [WIDTH-1:0] stk_top,
  input  logic             stk_empty,
  input  logic             stk_err,
  output logic [WIDTH-1:0] stk_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             instr_done,
  output logic             err,
  output logic [1:0]       err_code
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_DUP = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4, OP_SUB = 3'd5, OP_AND = 3'd6;
  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, WRITE, ERROR} state_t;
  state_t state, state_n;
  logic [2:0] op, op_n;
  logic [WIDTH-1:0] a, a_n, b, b_n, data_n;
  logic push_n, pop_n, done_n;
  logic [1:0] code_n;
  // Requests are registered, so the first pop is decided at acceptance while the stack is stable.
  always_comb begin
    state_n = state;
    op_n = op;
    a_n = a;
    b_n = b;
    data_n = stk_data;
    push_n = 1'b0;
    pop_n = 1'b0;
    done_n = 1'b0;
    code_n = err_code;
    if (state != ERROR && stk_err) begin
      state_n = ERROR;
      code_n = 2'b10;
    end else begin
      case (state)
        IDLE: if (instr_valid && instr_ready) begin
          op_n = instr_op;
          state_n = instr_op == OP_NOP ? IDLE : instr_op == OP_PUSH ? WRITE : FETCH_A;
          push_n = instr_op == OP_PUSH;
          data_n = instr_op == OP_PUSH ? instr_imm : stk_data;
          pop_n = !stk_empty && instr_op != OP_NOP && instr_op != OP_PUSH && instr_op != OP_DUP;
          done_n = instr_op == OP_NOP || instr_op == OP_PUSH || (instr_op == OP_POP && !stk_empty);
        end
        FETCH_A: if (stk_empty) begin
          state_n = ERROR;
          code_n = 2'b01;
        end else begin
          a_n = stk_top;
          state_n = op == OP_POP ? IDLE : op == OP_DUP ? WRITE : FETCH_B;
          push_n = op == OP_DUP;
          done_n = op == OP_DUP;
          data_n = op == OP_DUP ? stk_top : stk_data;
          pop_n = op != OP_POP && op != OP_DUP;
        end
        FETCH_B: if (stk_empty) begin
          state_n = ERROR;
          code_n = 2'b01;
        end else begin
          b_n = stk_top;
          state_n = WRITE;
          push_n = 1'b1;
          done_n = 1'b1;
          data_n = op == OP_ADD ? b_n + a : op == OP_SUB ? b_n - a : op == OP_AND ? b_n & a : b_n ^ a;
        end
        WRITE: state_n = IDLE;
        ERROR: state_n = ERROR;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op <= OP_NOP;
      a <= '0;
      b <= '0;
      stk_data <= '0;
      stk_push <= 1'b0;
      stk_pop <= 1'b0;
      instr_done <= 1'b0;
      instr_ready <= 1'b0;
      err <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_n;
      op <= op_n;
      a <= a_n;
      b <= b_n;
      stk_data <= data_n;
      stk_push <= push_n;
      stk_pop <= pop_n;
      instr_done <= done_n;
      instr_ready <= state_n == IDLE;
      err <= state_n == ERROR;
      err_code <= code_n;
    end
  end
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb_stack_alu_sequencer: directed checks of the sequencer against a behavioural program stack.
module tb_stack_alu_sequencer;
  localparam int W = 18;
  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, AND = 3'd6, XOR = 3'd7;
  logic clock, reset, instr_valid, instr_ready, stk_empty, stk_err;
  logic stk_push, stk_pop, instr_done, err;
  logic [2:0] instr_op;
  logic [1:0] err_code;
  logic [W-1:0] instr_imm, stk_top, stk_data;
  logic [W-1:0] mem [16];
  logic [4:0] sp;
  int push_cnt, pop_cnt, vectors, miscompares, q0, p0;

  stack_alu_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .stk_top(stk_top), .stk_empty(stk_empty),
    .stk_err(stk_err), .stk_data(stk_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .instr_done(instr_done), .err(err), .err_code(err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program stack: a request seen at an edge is visible on stk_top/stk_empty in the next cycle.
  assign stk_empty = sp == 5'd0;
  assign stk_top = sp == 5'd0 ? '0 : mem[sp[3:0] - 4'd1];
  always @(posedge clock) begin
    if (reset) sp <= 5'd0;
    else if (stk_push && sp < 5'd16) begin
      mem[sp[3:0]] <= stk_data;
      sp <= sp + 5'd1;
    end else if (stk_pop && sp > 5'd0) sp <= sp - 5'd1;
    if (!reset && stk_push) push_cnt <= push_cnt + 1;
    if (!reset && stk_pop) pop_cnt <= pop_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic p, input logic q, input logic d,
                          input logic r, input logic e, input logic [1:0] c, input logic [W-1:0] dat);
    logic [W+6:0] obs, exp;
    obs = {stk_push, stk_pop, instr_done, instr_ready, err, err_code, stk_data};
    exp = {p, q, d, r, e, c, dat};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: push/pop/done/rdy/err/code/data observed %b/%b/%b/%b/%b/%b/%h expected %b/%b/%b/%b/%b/%b/%h",
             tag, obs[W+6], obs[W+5], obs[W+4], obs[W+3], obs[W+2], obs[W+1:W], obs[W-1:0],
             p, q, d, r, e, c, dat);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] imm);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    assert (instr_ready === 1'b1) else begin
      miscompares++;
      $error("FAIL issue_ready: observed %b expected 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr_op = op;
    instr_imm = imm;
    tick();
    instr_valid = 1'b0;
    instr_op = NOP;
    instr_imm = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    push_cnt = 0;
    pop_cnt = 0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_op = NOP;
    instr_imm = '0;
    stk_err = 1'b0;
    tick();
    tick();
    expect_o("reset_state", 0, 0, 0, 0, 0, 2'b00, 18'h0);
    reset = 1'b0;
    tick();
    expect_o("ready_after_reset", 0, 0, 0, 1, 0, 2'b00, 18'h0);
    issue(NOP, 18'h11);
    expect_o("nop_done", 0, 0, 1, 1, 0, 2'b00, 18'h0);
    tick();
    expect_o("nop_idle", 0, 0, 0, 1, 0, 2'b00, 18'h0);
    // PUSH 5, PUSH 3, SUB -> 2
    issue(PUSH, 18'd5);
    expect_o("push5", 1, 0, 1, 0, 0, 2'b00, 18'd5);
    tick();
    expect_o("push5_end", 0, 0, 0, 1, 0, 2'b00, 18'd5);
    issue(PUSH, 18'd3);
    expect_o("push3", 1, 0, 1, 0, 0, 2'b00, 18'd3);
    tick();
    p0 = pop_cnt;
    issue(SUB, 18'h0);
    expect_o("sub_c1", 0, 1, 0, 0, 0, 2'b00, 18'd3);
    tick();
    expect_o("sub_c2", 0, 1, 0, 0, 0, 2'b00, 18'd3);
    tick();
    expect_o("sub_c3_push", 1, 0, 1, 0, 0, 2'b00, 18'd2);
    tick();
    expect_o("sub_c4_ready", 0, 0, 0, 1, 0, 2'b00, 18'd2);
    chk_int("sub_pops", pop_cnt - p0, 2);
    // PUSH 0x3FFFF, PUSH 1, ADD -> 0
    issue(PUSH, 18'h3FFFF);
    expect_o("push_max", 1, 0, 1, 0, 0, 2'b00, 18'h3FFFF);
    tick();
    issue(PUSH, 18'd1);
    tick();
    issue(ADD, 18'h0);
    tick();
    tick();
    expect_o("add_wrap", 1, 0, 1, 0, 0, 2'b00, 18'h0);
    tick();
    expect_o("add_end", 0, 0, 0, 1, 0, 2'b00, 18'h0);
    issue(POP, 18'h0);
    expect_o("pop", 0, 1, 1, 0, 0, 2'b00, 18'h0);
    tick();
    expect_o("pop_end", 0, 0, 0, 1, 0, 2'b00, 18'h0);
    chk_int("pop_depth", int'(sp), 1);
    // ADD on empty stack -> underflow
    do_reset();
    q0 = push_cnt;
    p0 = pop_cnt;
    issue(ADD, 18'h0);
    expect_o("uf_c1", 0, 0, 0, 0, 0, 2'b00, 18'h0);
    tick();
    expect_o("uf_err", 0, 0, 0, 0, 1, 2'b01, 18'h0);
    tick();
    tick();
    tick();
    expect_o("uf_hold", 0, 0, 0, 0, 1, 2'b01, 18'h0);
    chk_int("uf_pops", pop_cnt - p0, 0);
    chk_int("uf_pushes", push_cnt - q0, 0);
    // stk_err during FETCH_B of AND
    do_reset();
    issue(PUSH, 18'd4);
    tick();
    issue(PUSH, 18'd6);
    tick();
    q0 = push_cnt;
    issue(AND, 18'h0);
    expect_o("se_c1", 0, 1, 0, 0, 0, 2'b00, 18'd6);
    tick();
    stk_err = 1'b1;
    tick();
    expect_o("se_err", 0, 0, 0, 0, 1, 2'b10, 18'd6);
    stk_err = 1'b0;
    tick();
    tick();
    expect_o("se_hold", 0, 0, 0, 0, 1, 2'b10, 18'd6);
    chk_int("se_pushes", push_cnt - q0, 0);
    // PUSH 7, DUP
    do_reset();
    q0 = push_cnt;
    p0 = pop_cnt;
    issue(PUSH, 18'd7);
    tick();
    issue(DUP, 18'h0);
    expect_o("dup_c1", 0, 0, 0, 0, 0, 2'b00, 18'd7);
    tick();
    expect_o("dup_push", 1, 0, 1, 0, 0, 2'b00, 18'd7);
    tick();
    expect_o("dup_end", 0, 0, 0, 1, 0, 2'b00, 18'd7);
    chk_int("dup_pushes", push_cnt - q0, 2);
    chk_int("dup_pops", pop_cnt - p0, 0);
    chk_int("dup_depth", int'(sp), 2);
    // reset during FETCH_B of XOR, then PUSH 9
    issue(PUSH, 18'd1);
    tick();
    issue(PUSH, 18'd2);
    tick();
    issue(XOR, 18'h0);
    tick();
    q0 = push_cnt;
    reset = 1'b1;
    tick();
    expect_o("rst_mid", 0, 0, 0, 0, 0, 2'b00, 18'h0);
    tick();
    reset = 1'b0;
    tick();
    expect_o("rst_ready", 0, 0, 0, 1, 0, 2'b00, 18'h0);
    chk_int("rst_pushes", push_cnt - q0, 0);
    issue(PUSH, 18'd9);
    expect_o("push9", 1, 0, 1, 0, 0, 2'b00, 18'd9);
    tick();
    expect_o("push9_end", 0, 0, 0, 1, 0, 2'b00, 18'd9);
    chk_int("push9_top", int'(stk_top), 9);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
